// File: rtl/sdram_write_buffer_pkg.sv
// Shared definitions for the SDRAM posted-write buffer.
//   wb_state_e   : drain FSM state encoding (IDLE = 0, REQ = 1)
//   entry_width  : width of one FIFO entry {address, data}
package sdram_write_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_e;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/sdram_write_buffer_sync_fifo.sv
// Single-clock FIFO used to hold posted SDRAM writes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointers/count only)
//   push, din : write din at the tail (ignored when full)
//   pop       : discard the head entry (ignored when empty)
//   head      : current head entry, valid whenever count != 0
//   count     : number of stored entries, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is data only; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are log2(DEPTH) bits and wrap naturally; count carries the
  // extra bit that distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_write_buffer.sv
// Posted-write buffer between the SDRAM/GPIO write demux and the SDRAM
// controller. Every SDRAM-bound write is queued; the queue is drained one
// entry at a time over a req/ack handshake.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en_sdram       : write strobe from the demux (at most one per cycle)
//   wr_data_sdram     : write data
//   wr_address        : write address, forwarded unchanged
//   buf_full          : queue full, the pipeline must stall writes
//   buf_empty         : queue empty and no request outstanding
//   overflow_err      : sticky, a write arrived while full (cleared by rst)
//   sdram_wr_req      : request to the controller
//   sdram_wr_addr/data: request payload, stable while req is high
//   sdram_wr_ack      : controller accepted the current request
module sdram_write_buffer
  import sdram_write_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_sdram,
  input  logic [DATA_WIDTH-1:0] wr_data_sdram,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  output logic                  buf_full,
  output logic                  buf_empty,
  output logic                  overflow_err,
  output logic                  sdram_wr_req,
  output logic [ADDR_WIDTH-1:0] sdram_wr_addr,
  output logic [DATA_WIDTH-1:0] sdram_wr_data,
  input  logic                  sdram_wr_ack
);

  localparam int ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  wb_state_e          state;
  wb_state_e          state_nxt;
  logic               load_head;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Fullness comes from the registered count, so a pop on the same edge
  // never frees a slot for a push on that edge.
  assign push = wr_en_sdram && !fifo_full;
  assign pop  = (state == REQ) && sdram_wr_ack;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({wr_address, wr_data_sdram}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head is popped on the ack edge and the next one is only loaded from
  // IDLE, which inserts one bubble cycle between consecutive requests.
  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          load_head = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (sdram_wr_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Payload registers keep the last request while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_wr_addr <= '0;
      sdram_wr_data <= '0;
    end else if (load_head) begin
      {sdram_wr_addr, sdram_wr_data} <= fifo_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            overflow_err <= 1'b0;
    else if (wr_en_sdram && fifo_full)  overflow_err <= 1'b1;
  end

  assign sdram_wr_req = (state == REQ);
  assign buf_full     = fifo_full;
  assign buf_empty    = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_sdram_write_buffer.sv
module tb_sdram_write_buffer;

  logic        clk;
  logic        rst;
  logic        wr_en_sdram;
  logic [31:0] wr_data_sdram;
  logic [31:0] wr_address;
  logic        buf_full;
  logic        buf_empty;
  logic        overflow_err;
  logic        sdram_wr_req;
  logic [31:0] sdram_wr_addr;
  logic [31:0] sdram_wr_data;
  logic        sdram_wr_ack;

  int vectors     = 0;
  int miscompares = 0;

  sdram_write_buffer #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en_sdram   (wr_en_sdram),
    .wr_data_sdram (wr_data_sdram),
    .wr_address    (wr_address),
    .buf_full      (buf_full),
    .buf_empty     (buf_empty),
    .overflow_err  (overflow_err),
    .sdram_wr_req  (sdram_wr_req),
    .sdram_wr_addr (sdram_wr_addr),
    .sdram_wr_data (sdram_wr_data),
    .sdram_wr_ack  (sdram_wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic k, input logic eq,
                              input logic [31:0] ea, input logic [31:0] ed,
                              input logic ef, input logic ee, input logic eo);
    vec_t v;
    v.rst = r; v.wr = w; v.addr = a; v.data = d; v.ack = k;
    v.e_req = eq; v.e_addr = ea; v.e_data = ed;
    v.e_full = ef; v.e_empty = ee; v.e_ovf = eo;
    return v;
  endfunction

  function automatic logic [71:0] pack_out(input logic req, input logic [31:0] a,
                                           input logic [31:0] d, input logic full,
                                           input logic empty, input logic ovf);
    return {4'b0, req, a, d, full, empty, ovf};
  endfunction

  function automatic logic [71:0] dut_out();
    return pack_out(sdram_wr_req, sdram_wr_addr, sdram_wr_data,
                    buf_full, buf_empty, overflow_err);
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (req|addr|data|full|empty|ovf)", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en_sdram   = 1'b0;
    wr_address    = '0;
    wr_data_sdram = '0;
    sdram_wr_ack  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: single write and delayed ack
    vecs[0]  = mk(0,1,32'h10,32'hDEADBEEF,0, 0,32'h0,32'h0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,                  1,32'h10,32'hDEADBEEF,0,0,0);
    vecs[2]  = mk(0,0,0,0,0,                  1,32'h10,32'hDEADBEEF,0,0,0);
    vecs[3]  = mk(0,0,0,0,0,                  1,32'h10,32'hDEADBEEF,0,0,0);
    vecs[4]  = mk(0,0,0,0,1,                  0,32'h10,32'hDEADBEEF,0,1,0);
    vecs[5]  = mk(0,0,0,0,0,                  0,32'h10,32'hDEADBEEF,0,1,0);
    // Test 6: ack while idle and empty
    vecs[6]  = mk(0,0,0,0,1,                  0,32'h10,32'hDEADBEEF,0,1,0);
    // Test 2: fill, overflow, in-order drain
    vecs[7]  = mk(0,1,32'h100,32'h11110000,0, 0,32'h10,32'hDEADBEEF,0,0,0);
    vecs[8]  = mk(0,1,32'h101,32'h11110001,0, 1,32'h100,32'h11110000,0,0,0);
    vecs[9]  = mk(0,1,32'h102,32'h11110002,0, 1,32'h100,32'h11110000,0,0,0);
    vecs[10] = mk(0,1,32'h103,32'h11110003,0, 1,32'h100,32'h11110000,1,0,0);
    vecs[11] = mk(0,1,32'h104,32'h11110004,0, 1,32'h100,32'h11110000,1,0,1);
    vecs[12] = mk(0,0,0,0,1,                  0,32'h100,32'h11110000,0,0,1);
    vecs[13] = mk(0,0,0,0,0,                  1,32'h101,32'h11110001,0,0,1);
    vecs[14] = mk(0,0,0,0,1,                  0,32'h101,32'h11110001,0,0,1);
    vecs[15] = mk(0,0,0,0,0,                  1,32'h102,32'h11110002,0,0,1);
    vecs[16] = mk(0,0,0,0,1,                  0,32'h102,32'h11110002,0,0,1);
    vecs[17] = mk(0,0,0,0,0,                  1,32'h103,32'h11110003,0,0,1);
    vecs[18] = mk(0,0,0,0,1,                  0,32'h103,32'h11110003,0,1,1);
    vecs[19] = mk(0,0,0,0,0,                  0,32'h103,32'h11110003,0,1,1);
    // Test 3: push and ack on the same edge while full
    vecs[20] = mk(1,0,0,0,0,                  0,32'h0,32'h0,0,1,0);
    vecs[21] = mk(0,1,32'h200,32'hA5A50000,0, 0,32'h0,32'h0,0,0,0);
    vecs[22] = mk(0,1,32'h201,32'hA5A50001,0, 1,32'h200,32'hA5A50000,0,0,0);
    vecs[23] = mk(0,1,32'h202,32'hA5A50002,0, 1,32'h200,32'hA5A50000,0,0,0);
    vecs[24] = mk(0,1,32'h203,32'hA5A50003,0, 1,32'h200,32'hA5A50000,1,0,0);
    vecs[25] = mk(0,1,32'h2FF,32'hBAD0BAD0,1, 0,32'h200,32'hA5A50000,0,0,1);
    vecs[26] = mk(0,0,0,0,0,                  1,32'h201,32'hA5A50001,0,0,1);
    vecs[27] = mk(0,0,0,0,1,                  0,32'h201,32'hA5A50001,0,0,1);
    vecs[28] = mk(0,0,0,0,0,                  1,32'h202,32'hA5A50002,0,0,1);
    vecs[29] = mk(0,0,0,0,1,                  0,32'h202,32'hA5A50002,0,0,1);
    vecs[30] = mk(0,0,0,0,0,                  1,32'h203,32'hA5A50003,0,0,1);
    vecs[31] = mk(0,0,0,0,1,                  0,32'h203,32'hA5A50003,0,1,1);
    vecs[32] = mk(0,0,0,0,0,                  0,32'h203,32'hA5A50003,0,1,1);

    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", dut_out(), pack_out(0, 32'h0, 32'h0, 0, 1, 0));
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      rst           = vecs[i].rst;
      wr_en_sdram   = vecs[i].wr;
      wr_address    = vecs[i].addr;
      wr_data_sdram = vecs[i].data;
      sdram_wr_ack  = vecs[i].ack;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), dut_out(),
          pack_out(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_data,
                   vecs[i].e_full, vecs[i].e_empty, vecs[i].e_ovf));
    end
    rst = 1'b0;
    idle_inputs();

    // Test 4: continuous writes with ack tied high, bench stalls on full
    begin
      int          sent;
      int          received;
      logic        req_now;
      logic        prev_req;
      logic [31:0] a_now;
      logic [31:0] d_now;
      pulse_reset();
      sent = 0; received = 0; prev_req = 1'b0;
      sdram_wr_ack = 1'b1;
      for (int cyc = 0; cyc < 300 && received < 12; cyc++) begin
        wr_en_sdram   = (sent < 12) && !buf_full;
        wr_address    = 32'h300 + 32'(sent);
        wr_data_sdram = 32'hC0DE0000 + 32'(sent * 7);
        req_now = sdram_wr_req;
        a_now   = sdram_wr_addr;
        d_now   = sdram_wr_data;
        @(posedge clk); #1;
        if (wr_en_sdram) sent++;
        if (req_now) begin
          chk($sformatf("t4_entry%0d", received), {8'b0, a_now, d_now},
              {8'b0, 32'h300 + 32'(received), 32'hC0DE0000 + 32'(received * 7)});
          chk("t4_bubble", {71'b0, prev_req}, 72'b0);
          received++;
        end
        prev_req = req_now;
      end
      chk("t4_drained_count", 72'(received), 72'd12);
      idle_inputs();
      @(posedge clk); #1;
      chk("t4_final", {69'b0, buf_empty, overflow_err, sdram_wr_req}, {69'b0, 3'b100});
    end

    // Test 5: asynchronous reset while a request is pending and buffer full
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en_sdram   = 1'b1;
      wr_address    = 32'h400 + 32'(i);
      wr_data_sdram = 32'h55AA0000 + 32'(i);
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("t5_before_reset", dut_out(), pack_out(1, 32'h400, 32'h55AA0000, 1, 0, 1));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_reset", dut_out(), pack_out(0, 32'h0, 32'h0, 0, 1, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_no_stale%0d", i), dut_out(), pack_out(0, 32'h0, 32'h0, 0, 1, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
